seq_divider: RTL



---
 rtl/seq_divider_pkg.sv | 16 +
 rtl/seq_divider_addsub.sv | 15 +
 rtl/seq_divider.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types for the sequential signed divider: FSM state encoding and
// step-counter sizing helper.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_divider_addsub.sv
// Generic adder/subtractor: add_sub=1 adds, add_sub=0 subtracts (a - b).
module addsub #(
  parameter int unsigned w = 8
) (
  input  logic [w-1:0] a,
  input  logic [w-1:0] b,
  input  logic         add_sub,
  output logic [w-1:0] result
);

  always_comb begin
    result = add_sub ? (a + b) : (a - b);
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider, one quotient bit per clock, MSB first.
// Optional DIV_ZERO_SHORTCUT_EN: zero divisor skips RUN/FIX and finishes in one cycle.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned dw = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [dw-1:0] dividend,
  input  logic [dw-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [dw-1:0] quotient,
  output logic [dw-1:0] remainder,
  output logic          dbz,
  output logic          ovf
);

  localparam int unsigned CW = cnt_width(dw);

  state_t        state, state_nxt;
  logic [dw-1:0] dmag, vmag, qmag, dividend_q;
  // Partial remainder is always below |divisor| <= 2^(dw-1), so dw bits hold it;
  // the extra trial bit lives only in the shifted/trial values.
  logic [dw-1:0] prem;
  logic [dw:0]   shifted, trial;
  logic [CW-1:0] cnt;
  logic          sign_q, sign_r, ovf_case;

  assign shifted = {prem, dmag[dw-1]};

  addsub #(.w(dw + 1)) u_trial (
    .a       (shifted),
    .b       ({1'b0, vmag}),
    .add_sub (1'b0),
    .result  (trial)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef DIV_ZERO_SHORTCUT_EN
          state_nxt = (divisor == '0) ? DONE : RUN;
`else
          state_nxt = RUN;
`endif
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == CW'(dw - 1)) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmag       <= '0;
      vmag       <= '0;
      qmag       <= '0;
      dividend_q <= '0;
      prem       <= '0;
      cnt        <= '0;
      sign_q     <= 1'b0;
      sign_r     <= 1'b0;
      ovf_case   <= 1'b0;
      quotient   <= '0;
      remainder  <= '0;
      dbz        <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dmag       <= dividend[dw-1] ? -dividend : dividend;
            vmag       <= divisor[dw-1] ? -divisor : divisor;
            dividend_q <= dividend;
            sign_q     <= dividend[dw-1] ^ divisor[dw-1];
            sign_r     <= dividend[dw-1];
            ovf_case   <= (dividend == {1'b1, {(dw-1){1'b0}}}) && (divisor == '1);
            prem       <= '0;
            qmag       <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
`ifdef DIV_ZERO_SHORTCUT_EN
            if (divisor == '0) begin
              dbz       <= 1'b1;
              quotient  <= '1;
              remainder <= dividend;
            end else begin
              dbz <= 1'b0;
            end
`else
            dbz <= 1'b0;
`endif
          end
        end
        RUN: begin
          dmag <= {dmag[dw-2:0], 1'b0};
          qmag <= {qmag[dw-2:0], ~trial[dw]};
          prem <= trial[dw] ? shifted[dw-1:0] : trial[dw-1:0];
          cnt  <= cnt + CW'(1);
        end
        FIX: begin
          if (vmag == '0) begin
            dbz       <= 1'b1;
            ovf       <= 1'b0;
            quotient  <= '1;
            remainder <= dividend_q;
          end else begin
            ovf       <= ovf_case;
            quotient  <= sign_q ? -qmag : qmag;
            remainder <= sign_r ? -prem : prem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
